ddr3_ui_arb2: RTL and testbench
===============================

# ddr3_ui_arb2

Two-port arbiter that shares the single DDR3 memory-controller user interface between two requesters. Typical pairing is a write-stream client and a read-stream client. Runs in the controller's user clock domain (the `clk_out` divided clock) and drives the `app_*` command/write-data signals directly. Grants are round-robin. Each accepted request is issued as exactly one BL8 command (128-bit beat). Read data, which the controller returns in order, is routed back to the originating port through a tag FIFO.

## Interface
- ADDR_WIDTH, 28: controller address width.
- APP_DATA_WIDTH, 128: user data width, one beat per burst.
- APP_MASK_WIDTH, 16: write byte-mask width.
- TAG_DEPTH, 16: maximum outstanding reads; power of two, ≥2.

Ports:
- clk  in  1  user clock (controller `clk_out`).
- rst  in  1  synchronous, active-high reset.
- init_calib_complete  in  1  controller calibration done; no request is accepted while low.
- req0_en / req1_en  in  1  port request valid; held with its fields until ack.
- req0_rd / req1_rd  in  1  1 = read, 0 = write.
- req0_addr / req1_addr  in  ADDR_WIDTH  address.
- req0_wdata / req1_wdata  in  APP_DATA_WIDTH  write data; ignored for reads.
- req0_wmask / req1_wmask  in  APP_MASK_WIDTH  write mask, 1 = byte masked.
- req0_ack / req1_ack  out  1  one-cycle accept pulse.
- rd0_valid / rd1_valid  out  1  read beat for that port.
- rd_data_o  out  APP_DATA_WIDTH  read data, shared by both ports.
- app_rdy  in  1  controller `cmd_ready`.
- app_wdf_rdy  in  1  controller `wr_data_rdy`.
- app_en  out  1  command strobe.
- app_cmd  out  3  3'b000 write, 3'b001 read.
- app_addr  out  ADDR_WIDTH  command address.
- app_wdf_wren / app_wdf_end  out  1  write-data strobe and last beat; always equal.
- app_wdf_data  out  APP_DATA_WIDTH  write data.
- app_wdf_mask  out  APP_MASK_WIDTH  write mask.
- app_rd_data_valid  in  1  controller read-data valid.
- app_rd_data  in  APP_DATA_WIDTH  controller read data.
- tag_err  out  1  sticky: read data arrived with the tag FIFO empty.

## Operation
- FSM with two states, IDLE and ISSUE; reset state is IDLE.
- Eligibility: port N is eligible when `reqN_en` is high. A read additionally requires `tag_count < TAG_DEPTH`. Nothing is eligible while `init_calib_complete` is low.
- IDLE, single eligible port: that port wins.
- IDLE, both ports eligible: the port that did not win last wins. `last_grant` resets to 1, so port 0 wins the first tie.
- `reqN_ack` is combinational: high for the winning port while in IDLE.
- On the ack edge: latch rd/addr/wdata/wmask into the command registers, update `last_grant`, go to ISSUE.
- ISSUE, fire condition: `app_rdy` high, and for writes `app_wdf_rdy` also high.
- On fire:
  - `app_en` is high (combinational on the fire condition).
  - For a write, `app_wdf_wren` and `app_wdf_end` are also high.
  - For a read, push the port id into the tag FIFO.
  - Return to IDLE.
- ISSUE without the fire condition: hold state; `app_en` and `app_wdf_wren` stay low.
- `app_cmd`, `app_addr`, `app_wdf_data` and `app_wdf_mask` always drive the latched registers.
- Read return: on `app_rd_data_valid`, pop the tag FIFO. Next cycle, register `rd_data_o` and pulse `rdN_valid` for the popped id.
- Push and pop in the same cycle leave the count unchanged.
- `app_rd_data_valid` with the FIFO empty: set `tag_err`, no `rdN_valid`, no pointer change.
- Reset, including mid-issue: state → IDLE, FIFO pointers and count → 0, `last_grant` → 1. All outputs are 0, including `tag_err` and the command registers. Any in-flight transaction is abandoned.

## Timing
- Request sampled with ack at edge T. Earliest `app_en` is cycle T+1 (ISSUE). Next ack is no earlier than T+2.
- Peak throughput: one command per 2 clocks.
- Read data latency through the block: 1 clock (`app_rd_data_valid` at cycle C → `rdN_valid` at C+1).
- Tag FIFO full: read requests are not acked; writes are still served, including in a tie.
- `app_rdy` is never ignored: `app_en` is never high while `app_rdy` is low.
- Writes: `app_wdf_wren` is never high while `app_wdf_rdy` is low.

## Test plan
- Reset, then `init_calib_complete`=0 with both ports requesting: no ack, `app_en`=0 for 20 cycles. Raise calib: port 0 acked first.
- Both ports writing continuously, `app_rdy` and `app_wdf_rdy`=1: acks alternate 0,1,0,1. `app_en`, `app_wdf_wren` and `app_wdf_end` pulse every 2nd cycle with the matching addr/data/mask.
- Port 0 reads addr 0x10, 0x20 and port 1 reads addr 0x30, interleaved; controller returns data A, B, C in order: `rd0_valid`, `rd1_valid`, `rd0_valid` are routed per issue order, each 1 cycle after `app_rd_data_valid`.
- Write issued with `app_rdy`=1 and `app_wdf_rdy`=0 for 5 cycles: FSM holds ISSUE with `app_en`=0, then fires in the cycle `app_wdf_rdy` rises.
- 16 reads issued with no return data: the 17th read is not acked, while a port-1 write is still acked and issued. One return frees a slot, and the read is acked on the following IDLE.
- `app_rd_data_valid` with no outstanding reads sets `tag_err`=1, which holds until `rst`. Asserting `rst` while in ISSUE yields IDLE, `app_en`=0 and count 0 on the next cycle.

Source files
------------

// File: rtl/ddr3_ui_arb2.sv
`default_nettype none
// ============================================================================
// Module      : ddr3_ui_arb2
// Description : Round-robin two-port arbiter onto the DDR3 controller user
//               interface. Read data is steered back to the issuing port by a
//               tag FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ddr3_ui_arb2 #(
    parameter int ADDR_WIDTH     = 28,
    parameter int APP_DATA_WIDTH = 128,
    parameter int APP_MASK_WIDTH = 16,
    parameter int TAG_DEPTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      init_calib_complete,
    input  logic                      req0_en,
    input  logic                      req0_rd,
    input  logic [ADDR_WIDTH-1:0]     req0_addr,
    input  logic [APP_DATA_WIDTH-1:0] req0_wdata,
    input  logic [APP_MASK_WIDTH-1:0] req0_wmask,
    output logic                      req0_ack,
    input  logic                      req1_en,
    input  logic                      req1_rd,
    input  logic [ADDR_WIDTH-1:0]     req1_addr,
    input  logic [APP_DATA_WIDTH-1:0] req1_wdata,
    input  logic [APP_MASK_WIDTH-1:0] req1_wmask,
    output logic                      req1_ack,
    output logic                      rd0_valid,
    output logic                      rd1_valid,
    output logic [APP_DATA_WIDTH-1:0] rd_data_o,
    input  logic                      app_rdy,
    input  logic                      app_wdf_rdy,
    output logic                      app_en,
    output logic [2:0]                app_cmd,
    output logic [ADDR_WIDTH-1:0]     app_addr,
    output logic                      app_wdf_wren,
    output logic                      app_wdf_end,
    output logic [APP_DATA_WIDTH-1:0] app_wdf_data,
    output logic [APP_MASK_WIDTH-1:0] app_wdf_mask,
    input  logic                      app_rd_data_valid,
    input  logic [APP_DATA_WIDTH-1:0] app_rd_data,
    output logic                      tag_err
);

    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_TAG_FULL = CNT_W'(TAG_DEPTH);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_last_grant;
    logic                      r_cmd_rd;
    logic                      r_cmd_port;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [APP_DATA_WIDTH-1:0] r_wdata;
    logic [APP_MASK_WIDTH-1:0] r_wmask;
    logic                      r_tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]          r_wr_ptr;
    logic [PTR_W-1:0]          r_rd_ptr;
    logic [CNT_W-1:0]          r_tag_count;

    logic w_tag_full;
    logic w_tag_empty;
    logic w_elig0;
    logic w_elig1;
    logic w_grant0;
    logic w_grant1;
    logic w_push;
    logic w_pop;

    assign w_tag_full  = (r_tag_count == C_TAG_FULL);
    assign w_tag_empty = (r_tag_count == '0);
    assign w_elig0     = init_calib_complete && req0_en && !(req0_rd && w_tag_full);
    assign w_elig1     = init_calib_complete && req1_en && !(req1_rd && w_tag_full);
    // On a tie the port that lost last time goes first.
    assign w_grant0    = w_elig0 && (!w_elig1 || r_last_grant);
    assign w_grant1    = w_elig1 && (!w_elig0 || !r_last_grant);

    assign app_cmd      = {2'b00, r_cmd_rd};
    assign app_addr     = r_addr;
    assign app_wdf_data = r_wdata;
    assign app_wdf_mask = r_wmask;
    assign app_wdf_end  = app_wdf_wren;

    assign w_push = app_en && r_cmd_rd;
    assign w_pop  = app_rd_data_valid && !w_tag_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        req0_ack     = 1'b0;
        req1_ack     = 1'b0;
        app_en       = 1'b0;
        app_wdf_wren = 1'b0;
        case (r_state)
            S_IDLE: begin
                req0_ack = w_grant0;
                req1_ack = w_grant1;
                if (w_grant0 || w_grant1) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (app_rdy && (r_cmd_rd || app_wdf_rdy)) begin
                    app_en       = 1'b1;
                    app_wdf_wren = !r_cmd_rd;
                    w_state_nxt  = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= 1'b1;
            r_cmd_rd     <= 1'b0;
            r_cmd_port   <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wmask      <= '0;
        end else if (req0_ack || req1_ack) begin
            r_last_grant <= req1_ack;
            r_cmd_port   <= req1_ack;
            r_cmd_rd     <= req1_ack ? req1_rd    : req0_rd;
            r_addr       <= req1_ack ? req1_addr  : req0_addr;
            r_wdata      <= req1_ack ? req1_wdata : req0_wdata;
            r_wmask      <= req1_ack ? req1_wmask : req0_wmask;
        end
    end

    // Tag storage carries no reset; the count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag_mem[r_wr_ptr] <= r_cmd_port;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_tag_count <= '0;
            rd0_valid   <= 1'b0;
            rd1_valid   <= 1'b0;
            rd_data_o   <= '0;
            tag_err     <= 1'b0;
        end else begin
            rd0_valid <= w_pop && !r_tag_mem[r_rd_ptr];
            rd1_valid <= w_pop &&  r_tag_mem[r_rd_ptr];
            if (w_pop) begin
                rd_data_o <= app_rd_data;
                r_rd_ptr  <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_tag_count <= r_tag_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_tag_count <= r_tag_count - CNT_W'(1);
            end
            if (app_rd_data_valid && w_tag_empty) begin
                tag_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ddr3_ui_arb2.sv
`default_nettype none
// ============================================================================
// Module      : tb_ddr3_ui_arb2
// Description : Directed self-checking bench for ddr3_ui_arb2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ddr3_ui_arb2;

    logic         clk = 1'b0;
    logic         rst;
    logic         init_calib_complete;
    logic         req0_en, req0_rd, req0_ack;
    logic [27:0]  req0_addr;
    logic [127:0] req0_wdata;
    logic [15:0]  req0_wmask;
    logic         req1_en, req1_rd, req1_ack;
    logic [27:0]  req1_addr;
    logic [127:0] req1_wdata;
    logic [15:0]  req1_wmask;
    logic         rd0_valid, rd1_valid;
    logic [127:0] rd_data_o;
    logic         app_rdy, app_wdf_rdy, app_en;
    logic [2:0]   app_cmd;
    logic [27:0]  app_addr;
    logic         app_wdf_wren, app_wdf_end;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic         app_rd_data_valid;
    logic [127:0] app_rd_data;
    logic         tag_err;

    int checks = 0;
    int errors = 0;

    logic [27:0]  exp_addr;
    logic [127:0] exp_data;
    logic [15:0]  exp_mask;

    ddr3_ui_arb2 dut (
        .clk(clk), .rst(rst), .init_calib_complete(init_calib_complete),
        .req0_en(req0_en), .req0_rd(req0_rd), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_wmask(req0_wmask), .req0_ack(req0_ack),
        .req1_en(req1_en), .req1_rd(req1_rd), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_wmask(req1_wmask), .req1_ack(req1_ack),
        .rd0_valid(rd0_valid), .rd1_valid(rd1_valid), .rd_data_o(rd_data_o),
        .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy), .app_en(app_en),
        .app_cmd(app_cmd), .app_addr(app_addr), .app_wdf_wren(app_wdf_wren),
        .app_wdf_end(app_wdf_end), .app_wdf_data(app_wdf_data),
        .app_wdf_mask(app_wdf_mask), .app_rd_data_valid(app_rd_data_valid),
        .app_rd_data(app_rd_data), .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; init_calib_complete = 1'b0;
        req0_en = 1'b0; req0_rd = 1'b0; req0_addr = '0; req0_wdata = '0; req0_wmask = '0;
        req1_en = 1'b0; req1_rd = 1'b0; req1_addr = '0; req1_wdata = '0; req1_wmask = '0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data_valid = 1'b0; app_rd_data = '0;
        repeat (3) tick();
        #1;
        chk("reset_ctl", 128'({req1_ack, req0_ack, app_en, app_wdf_wren, rd1_valid, rd0_valid, tag_err}), 128'(0));
        chk("reset_cmd", 128'({app_cmd, app_addr}), 128'(0));
        chk("reset_rdata", rd_data_o, 128'(0));
        rst = 1'b0;
        tick();

        // Calibration gate
        req0_en = 1'b1; req0_addr = 28'h0000_001; req0_wdata = {4{32'h1111_0000}}; req0_wmask = 16'h000F;
        req1_en = 1'b1; req1_addr = 28'h0000_002; req1_wdata = {4{32'h2222_0000}}; req1_wmask = 16'hF000;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("calib_gate", 128'({req1_ack, req0_ack, app_en}), 128'(0));
            tick();
        end
        init_calib_complete = 1'b1;

        // Continuous writes from both ports alternate, starting with port 0
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("wr_ack", 128'({req1_ack, req0_ack, app_en}), 128'((k % 2) ? 3'b100 : 3'b010));
            if (k % 2) begin
                exp_addr = req1_addr; exp_data = req1_wdata; exp_mask = req1_wmask;
            end else begin
                exp_addr = req0_addr; exp_data = req0_wdata; exp_mask = req0_wmask;
            end
            tick();
            if (k % 2) begin
                req1_addr = req1_addr + 28'h100; req1_wdata = ~req1_wdata; req1_wmask = ~req1_wmask;
            end else begin
                req0_addr = req0_addr + 28'h100; req0_wdata = ~req0_wdata; req0_wmask = ~req0_wmask;
            end
            #1;
            chk("wr_fire", 128'({app_en, app_wdf_wren, app_wdf_end, req1_ack, req0_ack, app_cmd}), 128'(8'b1110_0000));
            chk("wr_addr", 128'(app_addr), 128'(exp_addr));
            chk("wr_data", app_wdf_data, exp_data);
            chk("wr_mask", 128'(app_wdf_mask), 128'(exp_mask));
            tick();
        end
        req0_en = 1'b0; req1_en = 1'b0;

        // Interleaved reads: port0 0x10, port1 0x30, port0 0x20
        req0_en = 1'b1; req0_rd = 1'b1; req0_addr = 28'h10;
        req1_en = 1'b1; req1_rd = 1'b1; req1_addr = 28'h30;
        #1; chk("rd_ack_a", 128'({req1_ack, req0_ack}), 128'(2'b01));
        tick();
        req0_addr = 28'h20;
        #1; chk("rd_fire_a", 128'({app_en, app_wdf_wren, app_cmd, app_addr}), 128'({2'b10, 3'b001, 28'h10}));
        tick();
        #1; chk("rd_ack_c", 128'({req1_ack, req0_ack}), 128'(2'b10));
        tick();
        req1_en = 1'b0;
        #1; chk("rd_fire_c", 128'({app_en, app_cmd, app_addr}), 128'({1'b1, 3'b001, 28'h30}));
        tick();
        #1; chk("rd_ack_b", 128'({req1_ack, req0_ack}), 128'(2'b01));
        tick();
        req0_en = 1'b0;
        #1; chk("rd_fire_b", 128'({app_en, app_cmd, app_addr}), 128'({1'b1, 3'b001, 28'h20}));
        tick();
        app_rd_data_valid = 1'b1; app_rd_data = {4{32'hAAAA_AAAA}};
        #1; chk("ret_lat", 128'({rd1_valid, rd0_valid}), 128'(0));
        tick();
        app_rd_data = {4{32'hBBBB_BBBB}};
        #1; chk("ret_a_vld", 128'({rd1_valid, rd0_valid}), 128'(2'b01));
        chk("ret_a_data", rd_data_o, {4{32'hAAAA_AAAA}});
        tick();
        app_rd_data = {4{32'hCCCC_CCCC}};
        #1; chk("ret_b_vld", 128'({rd1_valid, rd0_valid}), 128'(2'b10));
        chk("ret_b_data", rd_data_o, {4{32'hBBBB_BBBB}});
        tick();
        app_rd_data_valid = 1'b0;
        #1; chk("ret_c_vld", 128'({rd1_valid, rd0_valid}), 128'(2'b01));
        chk("ret_c_data", rd_data_o, {4{32'hCCCC_CCCC}});
        tick();
        #1; chk("ret_done", 128'({rd1_valid, rd0_valid, tag_err}), 128'(0));

        // Write stalled first by app_rdy, then by app_wdf_rdy
        req0_en = 1'b1; req0_rd = 1'b0; req0_addr = 28'h40;
        app_rdy = 1'b0;
        #1; chk("stall_ack", 128'({req1_ack, req0_ack}), 128'(2'b01));
        tick();
        req0_en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1; chk("stall_rdy", 128'({app_en, app_wdf_wren, app_wdf_end, req0_ack}), 128'(0));
            tick();
        end
        app_rdy = 1'b1; app_wdf_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1; chk("stall_wdf", 128'({app_en, app_wdf_wren, app_wdf_end, req0_ack}), 128'(0));
            tick();
        end
        app_wdf_rdy = 1'b1;
        #1; chk("stall_fire", 128'({app_en, app_wdf_wren, app_wdf_end, app_addr}), 128'({3'b111, 28'h40}));
        tick();
        #1; chk("stall_idle", 128'(app_en), 128'(0));

        // Fill the tag FIFO with 16 port-0 reads
        req0_en = 1'b1; req0_rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            req0_addr = 28'h100 + 28'(i);
            #1; chk("fill_ack", 128'({req1_ack, req0_ack}), 128'(2'b01));
            tick();
            #1; chk("fill_fire", 128'({app_en, app_cmd, app_addr}), 128'({1'b1, 3'b001, 28'h100 + 28'(i)}));
            tick();
        end
        req0_addr = 28'h200;
        req1_en = 1'b1; req1_rd = 1'b0; req1_addr = 28'h50;
        #1; chk("full_wr_ack", 128'({req1_ack, req0_ack}), 128'(2'b10));
        tick();
        req1_en = 1'b0;
        #1; chk("full_wr_fire", 128'({app_en, app_wdf_wren, app_addr}), 128'({2'b11, 28'h50}));
        tick();
        #1; chk("full_rd_block", 128'({req1_ack, req0_ack}), 128'(0));
        tick();
        app_rd_data_valid = 1'b1; app_rd_data = {4{32'hDDDD_DDDD}};
        #1; chk("full_rd_block2", 128'({req1_ack, req0_ack}), 128'(0));
        tick();
        app_rd_data_valid = 1'b0;
        #1; chk("free_slot", 128'({rd1_valid, rd0_valid, req1_ack, req0_ack}), 128'(4'b0101));
        chk("free_data", rd_data_o, {4{32'hDDDD_DDDD}});
        tick();
        req0_en = 1'b0;
        #1; chk("free_fire", 128'({app_en, app_cmd, app_addr}), 128'({1'b1, 3'b001, 28'h200}));
        tick();
        for (int i = 0; i < 16; i++) begin
            app_rd_data_valid = 1'b1; app_rd_data = 128'(i + 1);
            tick();
            #1; chk("drain", 128'({rd1_valid, rd0_valid, rd_data_o[7:0]}), 128'({2'b01, 8'(i + 1)}));
        end
        app_rd_data_valid = 1'b0;
        tick();
        #1; chk("drain_end", 128'({rd1_valid, rd0_valid, tag_err}), 128'(0));

        // Orphan read data
        app_rd_data_valid = 1'b1;
        tick();
        app_rd_data_valid = 1'b0;
        #1; chk("tag_err_set", 128'({tag_err, rd1_valid, rd0_valid}), 128'(3'b100));
        repeat (3) tick();
        #1; chk("tag_err_sticky", 128'(tag_err), 128'(1));

        // One read outstanding, then reset while a write sits in ISSUE
        req0_en = 1'b1; req0_rd = 1'b1; req0_addr = 28'h70;
        #1; chk("pre_rst_rd_ack", 128'({req1_ack, req0_ack}), 128'(2'b01));
        tick();
        req0_en = 1'b0;
        tick();
        req1_en = 1'b1; req1_rd = 1'b0; req1_addr = 28'h60;
        app_rdy = 1'b0;
        #1; chk("pre_rst_wr_ack", 128'({req1_ack, req0_ack}), 128'(2'b10));
        tick();
        req1_en = 1'b0;
        #1; chk("rst_issue_hold", 128'({app_en, app_addr}), 128'({1'b0, 28'h60}));
        rst = 1'b1;
        tick();
        rst = 1'b0; app_rdy = 1'b1;
        #1; chk("rst_idle", 128'({app_en, app_wdf_wren, tag_err, req1_ack, req0_ack, app_addr}), 128'(0));
        app_rd_data_valid = 1'b1;
        tick();
        app_rd_data_valid = 1'b0;
        #1; chk("rst_count0", 128'({tag_err, rd1_valid, rd0_valid}), 128'(3'b100));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
